// File: rtl/dau_sym_ascii_streamer_pkg.sv
// rtl/dau_sym_ascii_streamer_pkg.sv - DAU symbol codes, ASCII constants and streamer FSM states
package dau_sym_ascii_streamer_pkg;

   localparam int DAU_SYM_WIDTH = 5;

   localparam logic [DAU_SYM_WIDTH-1:0] SYM_DIGIT_0   = 5'h00;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_DIGIT_9   = 5'h09;
   // low nibble of PLUS..MINUS equals the low nibble of the ASCII operator
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_PLUS      = 5'h0B;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_MINUS     = 5'h0D;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_MUL       = 5'h10;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_DIV       = 5'h11;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_SEPARATOR = 5'h12;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_RESULT    = 5'h13;
   localparam logic [DAU_SYM_WIDTH-1:0] SYM_NEW_LINE  = 5'h14;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_MUL   = 8'h2A;
   localparam logic [7:0] ASCII_DIV   = 8'h2F;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_SEND_LF = 2'd2
   } state_e;

   typedef struct packed {
      logic       known;
      logic [7:0] ch;
   } map_t;

endpackage

// File: rtl/dau_sym_ascii_streamer_fifo.sv
// rtl/dau_sym_ascii_streamer_fifo.sv - synchronous FIFO with registered pointers, full/empty/level
module dau_sym_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // pointers carry one wrap bit so full and empty are distinguishable
   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_level = wr_ptr_q - rd_ptr_q;
   assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = i_push && !o_full && !i_flush;
   assign do_pop  = i_pop && !o_empty && !i_flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/dau_sym_ascii_streamer.sv
// rtl/dau_sym_ascii_streamer.sv - buffered DAU symbol to ASCII character streamer
module dau_sym_ascii_streamer
   import dau_sym_ascii_streamer_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int CRLF_ON_RESULT = 1,
   parameter int UNKNOWN_MODE   = 0,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   input  logic                      i_sym_valid,
   output logic                      o_sym_ready,
   input  logic [DAU_SYM_WIDTH-1:0]  i_symbol,
   output logic                      o_char_valid,
   input  logic                      i_char_ready,
   output logic [7:0]                o_char,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic                      o_busy,
   output logic [CNT_WIDTH-1:0]      o_drop_cnt
);

   function automatic map_t map_sym(input logic [DAU_SYM_WIDTH-1:0] s);
      map_t r;
      r.known = 1'b1;
      r.ch    = 8'h00;
      if (s >= SYM_PLUS && s <= SYM_MINUS) begin
         r.ch = {4'h2, s[3:0]};
      end else if (s <= SYM_DIGIT_9) begin
         r.ch = {4'h3, s[3:0]};
      end else begin
         case (s)
            SYM_MUL:       r.ch = ASCII_MUL;
            SYM_DIV:       r.ch = ASCII_DIV;
            SYM_SEPARATOR: r.ch = ASCII_SPACE;
            SYM_RESULT:    r.ch = ASCII_CR;
            SYM_NEW_LINE:  r.ch = ASCII_LF;
            default:       r.known = 1'b0;
         endcase
      end
      return r;
   endfunction

   state_e                  state_q, state_d;
   logic [7:0]              char_q, char_d;
   logic                    valid_q, valid_d;
   logic [CNT_WIDTH-1:0]    drop_q, drop_d;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [DAU_SYM_WIDTH-1:0] fifo_rdata;
   logic                    pop;
   logic                    load;
   logic                    accept;
   map_t                    m;

   dau_sym_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DAU_SYM_WIDTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_push  (i_sym_valid),
      .i_wdata (i_symbol),
      .i_pop   (pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (o_level)
   );

   assign o_sym_ready  = !fifo_full;
   assign o_char_valid = valid_q;
   assign o_char       = char_q;
   assign o_busy       = !fifo_empty || valid_q;
   assign o_drop_cnt   = drop_q;
   assign accept       = valid_q && i_char_ready;

   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      valid_d = valid_q;
      drop_d  = drop_q;
      pop     = 1'b0;
      load    = 1'b0;
      m       = map_sym(fifo_rdata);
      if (i_flush) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         char_d  = 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: load = 1'b1;
            ST_SEND: begin
               // only RESULT maps to CR, so the presented char identifies it
               if (accept) begin
                  if (CRLF_ON_RESULT != 0 && char_q == ASCII_CR) begin
                     char_d  = ASCII_LF;
                     state_d = ST_SEND_LF;
                  end else begin
                     load = 1'b1;
                  end
               end
            end
            ST_SEND_LF: load = accept;
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         endcase

         if (load) begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (m.known || UNKNOWN_MODE != 0) begin
                  char_d  = m.known ? m.ch : ASCII_QMARK;
                  valid_d = 1'b1;
                  state_d = ST_SEND;
               end else begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
                  if (drop_q != '1) drop_d = drop_q + 1'b1;
               end
            end else begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

endmodule

// File: tb/tb_dau_sym_ascii_streamer.sv
// tb/tb_dau_sym_ascii_streamer.sv - scoreboard bench for two streamer configurations
module tb_dau_sym_ascii_streamer;
   import dau_sym_ascii_streamer_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_sym_valid = 1'b0;
   logic [4:0]  i_symbol = '0;
   logic        i_char_ready = 1'b0;

   logic          d_sym_ready, d_valid, d_busy;
   logic [7:0]    d_char, d_drop;
   logic [LW-1:0] d_level;
   logic          a_sym_ready, a_valid, a_busy;
   logic [7:0]    a_char, a_drop;
   logic [LW-1:0] a_level;

   int checks = 0;
   int failures = 0;
   int drop_exp_d = 0;
   logic [7:0] q_d [$];
   logic [7:0] q_a [$];
   bit   held_d = 0, held_a = 0;
   logic [7:0] held_char_d, held_char_a;

   always #5 clk = ~clk;

   dau_sym_ascii_streamer #(.DEPTH(DEPTH), .CRLF_ON_RESULT(1), .UNKNOWN_MODE(0), .CNT_WIDTH(8)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
      .i_sym_valid(i_sym_valid), .o_sym_ready(d_sym_ready), .i_symbol(i_symbol),
      .o_char_valid(d_valid), .i_char_ready(i_char_ready), .o_char(d_char),
      .o_level(d_level), .o_busy(d_busy), .o_drop_cnt(d_drop));

   dau_sym_ascii_streamer #(.DEPTH(DEPTH), .CRLF_ON_RESULT(0), .UNKNOWN_MODE(1), .CNT_WIDTH(8)) u_alt (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
      .i_sym_valid(i_sym_valid), .o_sym_ready(a_sym_ready), .i_symbol(i_symbol),
      .o_char_valid(a_valid), .i_char_ready(i_char_ready), .o_char(a_char),
      .o_level(a_level), .o_busy(a_busy), .o_drop_cnt(a_drop));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // reference ASCII table, independent of the RTL nibble tricks
   function automatic bit ref_char(input logic [4:0] s, output logic [7:0] c);
      c = 8'h00;
      case (s)
         5'h00: c = "0"; 5'h01: c = "1"; 5'h02: c = "2"; 5'h03: c = "3"; 5'h04: c = "4";
         5'h05: c = "5"; 5'h06: c = "6"; 5'h07: c = "7"; 5'h08: c = "8"; 5'h09: c = "9";
         5'h0B: c = "+"; 5'h0C: c = ","; 5'h0D: c = "-";
         5'h10: c = "*"; 5'h11: c = "/"; 5'h12: c = " ";
         5'h13: c = 8'h0D; 5'h14: c = 8'h0A;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic enq(input logic [4:0] s, input bit to_d, input bit to_a);
      logic [7:0] c;
      bit known;
      known = ref_char(s, c);
      if (to_d) begin
         if (!known) drop_exp_d++;
         else begin
            q_d.push_back(c);
            if (s == SYM_RESULT) q_d.push_back(8'h0A);
         end
      end
      if (to_a) q_a.push_back(known ? c : 8'h3F);
   endtask

   task automatic try_push(input logic [4:0] s, output bit acc);
      i_sym_valid = 1'b1;
      i_symbol    = s;
      acc = d_sym_ready;
      enq(s, d_sym_ready, a_sym_ready);
      @(posedge clk); #1;
      i_sym_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (q_d.size() == 0 && q_a.size() == 0 && !d_busy && !a_busy) done = 1;
         else begin @(posedge clk); #1; end
      end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   always @(negedge clk) if (rst_n) begin
      if (d_valid && held_d) chk("d_hold", d_char, held_char_d);
      if (d_valid && i_char_ready) begin
         if (q_d.size() == 0) chk("d_unexpected_char", d_char, 32'hFFFF);
         else chk("d_char", d_char, q_d.pop_front());
         held_d = 0;
      end else begin
         held_d = d_valid;
         held_char_d = d_char;
      end
      if (a_valid && held_a) chk("a_hold", a_char, held_char_a);
      if (a_valid && i_char_ready) begin
         if (q_a.size() == 0) chk("a_unexpected_char", a_char, 32'hFFFF);
         else chk("a_char", a_char, q_a.pop_front());
         held_a = 0;
      end else begin
         held_a = a_valid;
         held_char_a = a_char;
      end
   end

   initial begin
      bit acc;
      int n_acc;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", d_valid, 0);
      chk("rst_char", d_char, 0);
      chk("rst_level", d_level, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_drop", d_drop, 0);
      chk("rst_ready", d_sym_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // back-to-back mapping and two-cycle latency
      i_char_ready = 1'b1;
      try_push(SYM_DIGIT_0 + 5'd4, acc);
      chk("lat_n1_valid", d_valid, 0);
      try_push(SYM_PLUS, acc);
      chk("lat_n2_valid", d_valid, 1);
      chk("lat_n2_char", d_char, 8'h34);
      try_push(SYM_DIGIT_0 + 5'd2, acc);
      chk("b2b_n3_char", d_char, 8'h2B);
      @(posedge clk); #1;
      chk("b2b_n4_char", d_char, 8'h32);
      drain("drain_basic");

      // RESULT under toggling back-pressure
      i_char_ready = 1'b0;
      try_push(SYM_RESULT, acc);
      for (int i = 0; i < 12; i++) begin
         i_char_ready = ~i_char_ready;
         @(posedge clk); #1;
      end
      i_char_ready = 1'b1;
      drain("drain_result");

      // unknown codes: dropped vs '?'
      try_push(5'h0A, acc);
      try_push(5'h0E, acc);
      try_push(5'h1F, acc);
      try_push(SYM_DIGIT_0 + 5'd7, acc);
      drain("drain_unknown");
      chk("drop_cnt_d", d_drop, drop_exp_d);
      chk("drop_cnt_a", a_drop, 0);

      // fill against stalled output
      i_char_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         try_push(5'(i % 10), acc);
         if (acc) n_acc++;
      end
      chk("fill_accepted", n_acc, DEPTH + 1);
      chk("fill_level", d_level, DEPTH);
      chk("fill_ready", d_sym_ready, 0);
      chk("fill_busy", d_busy, 1);
      i_char_ready = 1'b1;
      drain("drain_fill");

      // flush while LF pending
      i_char_ready = 1'b0;
      try_push(SYM_RESULT, acc);
      for (int i = 1; i <= 4; i++) try_push(5'(i), acc);
      @(posedge clk); #1;
      chk("pre_flush_char", d_char, 8'h0D);
      i_char_ready = 1'b1;
      @(posedge clk); #1;
      i_char_ready = 1'b0;
      chk("pre_flush_lf", d_char, 8'h0A);
      i_flush = 1'b1;
      q_d.delete();
      q_a.delete();
      @(posedge clk); #1;
      i_flush = 1'b0;
      chk("flush_valid", d_valid, 0);
      chk("flush_level", d_level, 0);
      chk("flush_busy", d_busy, 0);
      chk("flush_alt_level", a_level, 0);
      chk("flush_drop_kept", d_drop, drop_exp_d);
      i_char_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_flush_idle", d_valid, 0);

      // asynchronous reset mid-stream
      i_char_ready = 1'b0;
      try_push(SYM_DIGIT_0 + 5'd5, acc);
      try_push(SYM_DIGIT_0 + 5'd6, acc);
      try_push(SYM_DIGIT_0 + 5'd8, acc);
      #3;
      rst_n = 1'b0;
      #1;
      q_d.delete();
      q_a.delete();
      drop_exp_d = 0;
      chk("arst_valid", d_valid, 0);
      chk("arst_char", d_char, 0);
      chk("arst_level", d_level, 0);
      chk("arst_busy", d_busy, 0);
      chk("arst_drop", d_drop, 0);
      chk("arst_ready", d_sym_ready, 1);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      i_char_ready = 1'b1;
      try_push(SYM_DIGIT_0, acc);
      @(posedge clk); #1;
      chk("post_rst_char", d_char, 8'h30);
      drain("drain_post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dau_sym_ascii_streamer.md
Name: dau_sym_ascii_streamer

Overview:
Buffered, handshaked converter from DAU symbols to an ASCII character stream, placed between the calculator core's symbol output and the UART TX byte interface.
- Accepts symbols over valid/ready into a parametrised FIFO.
- Maps each symbol to ASCII and presents characters one per cycle under downstream back-pressure.
- Optionally expands RESULT to CR LF; unknown codes are dropped (and counted) or emitted as '?'.

Parameters:
DEPTH, 8, FIFO depth in symbols; power of 2, >= 2
CRLF_ON_RESULT, 1, 1: RESULT emits 0x0D then 0x0A; 0: RESULT emits 0x0D only
UNKNOWN_MODE, 0, 0: drop unmapped symbols; 1: emit 0x3F '?'
CNT_WIDTH, 8, width of saturating drop counter

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous clear of FIFO, FSM and presented char
i_sym_valid  in  1  input symbol valid
o_sym_ready  out  1  FIFO not full; = !full (combinational)
i_symbol  in  `DAU_SYM_WIDTH  symbol code
o_char_valid  out  1  registered; o_char valid
i_char_ready  in  1  downstream accepts o_char
o_char  out  8  registered ASCII byte
o_level  out  $clog2(DEPTH)+1  FIFO occupancy
o_busy  out  1  FIFO non-empty or o_char_valid
o_drop_cnt  out  CNT_WIDTH  saturating count of dropped symbols

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE; FIFO empty; o_char_valid=0, o_char=0x00, o_level=0, o_busy=0, o_drop_cnt=0; o_sym_ready=1.
- Push: when i_sym_valid & o_sym_ready. Full blocks push even if a pop occurs in the same cycle. No empty-FIFO bypass.
- Mapping:
  - PLUS..MINUS -> {4'h2, sym[3:0]}
  - MUL -> 0x2A; DIV -> 0x2F
  - digits 0..9 -> {4'h3, sym[3:0]}
  - SEPARATOR -> 0x20; RESULT -> 0x0D; NEW_LINE -> 0x0A
  - anything else is unknown.
- FSM states: IDLE, SEND, SEND_LF.
- IDLE: if FIFO non-empty, pop and map:
  - mapped, or unknown with UNKNOWN_MODE=1 -> load o_char, o_char_valid=1, go SEND.
  - unknown with UNKNOWN_MODE=0 -> o_drop_cnt++ (saturates at all-ones), stay IDLE.
- SEND: hold o_char/o_char_valid stable until i_char_ready. On accept:
  - char was 0x0D from RESULT and CRLF_ON_RESULT=1 -> load 0x0A, go SEND_LF (no pop).
  - else if FIFO non-empty -> pop and map in the same cycle (back-to-back, 1 char/cycle); a dropped unknown returns to IDLE with o_char_valid=0.
  - else -> o_char_valid=0, go IDLE.
- SEND_LF: on accept, same as SEND's "else" branches.
- Latency: symbol pushed in cycle N into an empty, idle block -> o_char_valid=1 in cycle N+2.
- i_flush (priority over push/pop): FIFO emptied, FSM=IDLE, o_char_valid=0 next cycle, pending LF discarded; o_drop_cnt kept.
- Reset mid-transfer: everything cleared immediately; a partially sent CR LF pair is lost.
- o_level updates the cycle after push/pop; simultaneous push and pop leave it unchanged.

Decomposition:
- Symbol codes and `DAU_SYM_WIDTH stay in the shared dau_symbols.vh header.
- Add ASCII constants (`ASCII_CR, `ASCII_LF, `ASCII_QMARK) and FSM state localparams in the same header.
- Sub-module dau_sym_fifo (parametrised DEPTH, WIDTH; sync, registered pointers, full/empty/level).
- Mapping is a function inside the streamer (combinational, returns {known, char}).

Test Plan:
- Push DIGIT_4, PLUS, DIGIT_2, i_char_ready=1 -> o_char 0x34,0x2B,0x32 on consecutive cycles; first valid 2 cycles after first push.
- Push RESULT with CRLF_ON_RESULT=1, i_char_ready toggling 0/1 -> 0x0D then 0x0A, each held stable while ready=0; with CRLF_ON_RESULT=0 -> 0x0D only.
- Push 3 unknown codes then DIGIT_7, UNKNOWN_MODE=0 -> only 0x37 emitted, o_drop_cnt=3; with UNKNOWN_MODE=1 -> 0x3F,0x3F,0x3F,0x37.
- i_char_ready=0, push DEPTH+2 symbols -> o_sym_ready falls after DEPTH accepts (one held in output, so DEPTH+1 total accepted), o_level=DEPTH; release ready -> all emitted in order, none lost or duplicated.
- Assert i_flush while SEND_LF pending with 4 symbols queued -> next cycle o_char_valid=0, o_level=0, o_busy=0; no LF emitted.
- Pull i_rst_n low asynchronously mid-stream -> all outputs at reset values before next clock edge; after release, a new DIGIT_0 yields 0x30.
